// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block sequencer and its read pipeline.
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int W_IDX_W    = 6;
  localparam int K_ADDR_W   = 6;

  typedef logic [W_IDX_W-1:0] widx_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAD_WAIT = 3'd1,
    ST_W_WAIT   = 3'd2,
    ST_ROUNDS   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_UPDATE   = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/sha256_rd_pipe.sv
// Delay line that carries each issued W read (valid + round index) forward
// by DEPTH cycles so it lines up with the W data arriving at the core.
module sha256_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vld_i,
  input  logic [IW-1:0] idx_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o,
  output logic          empty_o
);

  logic [DEPTH-1:0] vld_q;
  logic [IW-1:0]    idx_q [DEPTH];

  // Shift valid and index one stage per clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign vld_o   = vld_q[DEPTH-1];
  assign idx_o   = idx_q[DEPTH-1];
  // Empty only once the final stage has also been consumed.
  assign empty_o = ~|vld_q;

endmodule

// File: rtl/sha256_round_sched.sv
// Top-level sequencer for one SHA-256 block: hash init, padder/W-generator
// handshakes with timeout, 64 W/K reads, pipeline drain, hash update, done.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for main_go_sig
// PAD_WAIT  | hash_init issued, waiting for pad_rdy (timeout guarded)
// W_WAIT    | waiting for w_rdy (timeout guarded)
// ROUNDS    | issuing W/K reads, index 0..63 one per cycle
// DRAIN     | reads done, waiting for the read pipeline to empty
// UPDATE    | hash_update pulse
// DONE      | done/finish_sig pulse, back to IDLE
module sha256_round_sched
  import sha256_pkg::*;
#(
  parameter int W_RD_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                main_go_sig,
  input  logic                pad_rdy,
  input  logic                w_rdy,
  output logic                w_reg_read,
  output logic [W_IDX_W-1:0]  w_reg_addr,
  output logic [K_ADDR_W-1:0] k_addr,
  output logic                round_en,
  output logic [W_IDX_W-1:0]  round_idx,
  output logic                hash_init,
  output logic                hash_update,
  output logic                finish_sig,
  output logic                done,
  output logic                busy,
  output logic                err_timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e         state_q, state_d;
  widx_t          rcnt_q, rcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           err_q, err_d;
  logic           hash_init_q, hash_init_d;
  logic           hash_update_q, hash_update_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           w_reg_read_q, w_reg_read_d;

  logic           last_round;
  logic           tmo_hit;
  logic           in_wait;
  logic           rdy_now;
  logic           pipe_empty;

  assign last_round = (rcnt_q == widx_t'(NUM_ROUNDS - 1));
  assign tmo_hit    = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign in_wait    = (state_q == ST_PAD_WAIT) || (state_q == ST_W_WAIT);
  assign rdy_now    = (state_q == ST_PAD_WAIT) ? pad_rdy : w_rdy;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ready in the terminal-count cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (main_go_sig) state_d = ST_PAD_WAIT;
      ST_PAD_WAIT: if (pad_rdy)      state_d = ST_W_WAIT;
                   else if (tmo_hit) state_d = ST_IDLE;
      ST_W_WAIT:   if (w_rdy)        state_d = ST_ROUNDS;
                   else if (tmo_hit) state_d = ST_IDLE;
      ST_ROUNDS:   if (last_round)   state_d = ST_DRAIN;
      ST_DRAIN:    if (pipe_empty)   state_d = ST_UPDATE;
      ST_UPDATE:   state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output and counter next values; outputs are decoded from the next state
  // so every pulse appears exactly in the cycle its state is occupied.
  always_comb begin
    rcnt_d        = '0;
    tcnt_d        = '0;
    err_d         = err_q;
    hash_init_d   = 1'b0;
    hash_update_d = (state_d == ST_UPDATE);
    done_d        = (state_d == ST_DONE);
    busy_d        = (state_d != ST_IDLE);
    w_reg_read_d  = (state_d == ST_ROUNDS);

    if (state_q == ST_ROUNDS && !last_round) rcnt_d = rcnt_q + 1'b1;

    if (in_wait && state_d == state_q) tcnt_d = tcnt_q + 1'b1;

    if (state_q == ST_IDLE && main_go_sig) begin
      hash_init_d = 1'b1;
      err_d       = 1'b0;
    end

    if (in_wait && !rdy_now && tmo_hit) err_d = 1'b1;
  end

  // Counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt_q        <= '0;
      tcnt_q        <= '0;
      err_q         <= 1'b0;
      hash_init_q   <= 1'b0;
      hash_update_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      w_reg_read_q  <= 1'b0;
    end else begin
      rcnt_q        <= rcnt_d;
      tcnt_q        <= tcnt_d;
      err_q         <= err_d;
      hash_init_q   <= hash_init_d;
      hash_update_q <= hash_update_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      w_reg_read_q  <= w_reg_read_d;
    end
  end

  sha256_rd_pipe #(
    .DEPTH (W_RD_LAT),
    .IW    (W_IDX_W)
  ) u_rd_pipe (
    .clk_i   (clock),
    .rst_ni  (reset),
    .vld_i   (w_reg_read_q),
    .idx_i   (rcnt_q),
    .vld_o   (round_en),
    .idx_o   (round_idx),
    .empty_o (pipe_empty)
  );

  // rcnt_q is held at zero outside ROUNDS, so it doubles as the address.
  assign w_reg_read  = w_reg_read_q;
  assign w_reg_addr  = rcnt_q;
  assign k_addr      = K_ADDR_W'(rcnt_q);
  assign hash_init   = hash_init_q;
  assign hash_update = hash_update_q;
  assign finish_sig  = done_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sha256_round_sched.sv
// Bench for sha256_round_sched: two instances (read latency 1 and 3) share one
// stimulus stream; expected outputs come from a block-level timeline model.
module tb_sha256_round_sched;

  localparam int N   = 3200;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset, main_go_sig, pad_rdy, w_rdy;

  logic       rd1, ren1, hi1, hu1, fin1, dn1, bsy1, er1;
  logic [5:0] wa1, ka1, ri1;
  logic       rd3, ren3, hi3, hu3, fin3, dn3, bsy3, er3;
  logic [5:0] wa3, ka3, ri3;

  always #5 clock = ~clock;

  sha256_round_sched #(.W_RD_LAT(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clock(clock), .reset(reset), .main_go_sig(main_go_sig), .pad_rdy(pad_rdy), .w_rdy(w_rdy),
    .w_reg_read(rd1), .w_reg_addr(wa1), .k_addr(ka1), .round_en(ren1), .round_idx(ri1),
    .hash_init(hi1), .hash_update(hu1), .finish_sig(fin1), .done(dn1), .busy(bsy1),
    .err_timeout(er1));

  sha256_round_sched #(.W_RD_LAT(3), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clock(clock), .reset(reset), .main_go_sig(main_go_sig), .pad_rdy(pad_rdy), .w_rdy(w_rdy),
    .w_reg_read(rd3), .w_reg_addr(wa3), .k_addr(ka3), .round_en(ren3), .round_idx(ri3),
    .hash_init(hi3), .hash_update(hu3), .finish_sig(fin3), .done(dn3), .busy(bsy3),
    .err_timeout(er3));

  logic [25:0] act1, act3;
  assign act1 = {rd1, wa1, ka1, ren1, ri1, hi1, hu1, fin1, dn1, bsy1, er1};
  assign act3 = {rd3, wa3, ka3, ren3, ri3, hi3, hu3, fin3, dn3, bsy3, er3};

  bit          go_a  [N];
  bit          pad_a [N];
  bit          wr_a  [N];
  bit          rst_a [N];
  logic [25:0] exp_a [2][N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [25:0] pack(input bit rd, input int addr, input bit ren, input int idx,
                                       input bit hi, input bit hu, input bit dn, input bit bsy,
                                       input bit er);
    logic [5:0] a;
    logic [5:0] ix;
    a  = addr[5:0];
    ix = idx[5:0];
    return {rd, a, a, ren, ix, hi, hu, dn, dn, bsy, er};
  endfunction

  task automatic set_rng(input int which, input int from, input int to, input bit v);
    for (int i = from; i <= to && i < N; i++) begin
      case (which)
        0: go_a[i]  = v;
        1: pad_a[i] = v;
        2: wr_a[i]  = v;
        default: rst_a[i] = v;
      endcase
    end
  endtask

  // Directed scenarios first, then a random stretch, then a quiet tail.
  task automatic build_stim();
    int rst_left;
    for (int i = 0; i < N; i++) begin
      go_a[i] = 0; pad_a[i] = 0; wr_a[i] = 0; rst_a[i] = 0;
    end
    set_rng(3, 0, 1, 1);
    // nominal; ready levels drop mid-rounds
    set_rng(0, 3, 3, 1);
    set_rng(1, 10, 49, 1);
    set_rng(2, 20, 49, 1);
    // padder timeout, then a clean block
    set_rng(0, 100, 100, 1);
    set_rng(0, 125, 125, 1);
    set_rng(1, 126, 300, 1);
    set_rng(2, 126, 300, 1);
    // go pulsed while busy at round 30 (rounds start at 213)
    set_rng(0, 210, 210, 1);
    set_rng(0, 243, 243, 1);
    // W-generator timeout
    set_rng(0, 300, 300, 1);
    set_rng(2, 301, 356, 0);
    set_rng(1, 295, 330, 1);
    // pad_rdy arriving exactly on the terminal-count cycle
    set_rng(0, 340, 340, 1);
    set_rng(1, 331, 355, 0);
    set_rng(1, 356, 430, 1);
    set_rng(2, 357, 450, 1);
    // pad_rdy one cycle too late
    set_rng(0, 440, 440, 1);
    set_rng(1, 431, 456, 0);
    set_rng(1, 457, 700, 1);
    // w_rdy arriving exactly on the terminal-count cycle
    set_rng(0, 470, 470, 1);
    set_rng(2, 451, 486, 0);
    set_rng(2, 487, 700, 1);
    // reset while address 40 is issued (rounds start at 573), then restart
    set_rng(0, 570, 570, 1);
    set_rng(3, 613, 614, 1);
    set_rng(0, 620, 620, 1);
    // back-to-back with go held high
    set_rng(0, 700, 1000, 1);
    set_rng(1, 700, 1100, 1);
    set_rng(2, 700, 1100, 1);
    // random stretch
    rst_left = 0;
    for (int i = 1101; i < 3000; i++) begin
      go_a[i]  = ($urandom_range(24) == 0);
      pad_a[i] = ($urandom_range(9) == 0) ? !pad_a[i-1] : pad_a[i-1];
      wr_a[i]  = ($urandom_range(9) == 0) ? !wr_a[i-1]  : wr_a[i-1];
      if (rst_left == 0 && $urandom_range(499) == 0) rst_left = $urandom_range(2, 1);
      if (rst_left > 0) begin
        rst_a[i] = 1;
        rst_left--;
      end
    end
  endtask

  // Timeline model: for each accepted go, locate the ready edges in the input
  // streams and lay out the block's pulses by offset from the first read.
  task automatic build_exp(input int d, input int lat);
    bit err, tmo, cut;
    int c, s, p, q, r, e, k;
    for (int i = 0; i < N; i++) exp_a[d][i] = '0;
    err = 0;
    c = 0;
    while (c < N) begin
      if (rst_a[c]) begin
        err = 0;
        c++;
      end else begin
        exp_a[d][c] = pack(0, 0, 0, 0, 0, 0, 0, 0, err);
        if (!go_a[c]) c++;
        else begin
          s = c + 1; tmo = 0; r = 0; cut = 0;
          p = -1;
          for (int i = s; i < s + TMO && i < N; i++) if (pad_a[i] && p < 0) p = i;
          if (p < 0) begin
            tmo = 1; e = s + TMO;
          end else begin
            q = -1;
            for (int i = p + 1; i <= p + TMO && i < N; i++) if (wr_a[i] && q < 0) q = i;
            if (q < 0) begin
              tmo = 1; e = p + 1 + TMO;
            end else begin
              r = q + 1; e = r + 67 + lat;
            end
          end
          c = e;
          k = s;
          while (k < e && k < N && !cut) begin
            if (rst_a[k]) begin
              cut = 1; c = k;
            end else begin
              exp_a[d][k] = pack(!tmo && k >= r && k < r + 64,
                                 (!tmo && k >= r && k < r + 64) ? k - r : 0,
                                 !tmo && k >= r + lat && k < r + lat + 64,
                                 (!tmo && k >= r + lat && k < r + lat + 64) ? k - r - lat : 0,
                                 k == s,
                                 !tmo && k == r + 65 + lat,
                                 !tmo && k == r + 66 + lat,
                                 1, 0);
              k++;
            end
          end
          err = (!cut && tmo);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; main_go_sig = 1'b0; pad_rdy = 1'b0; w_rdy = 1'b0;
    build_stim();
    build_exp(0, 1);
    build_exp(1, 3);
    for (int c = 0; c < N; c++) begin
      @(posedge clock);
      #1;
      reset       = !rst_a[c];
      main_go_sig = go_a[c];
      pad_rdy     = pad_a[c];
      w_rdy       = wr_a[c];
      @(negedge clock);
      chk($sformatf("lat1 c%0d", c), 32'(act1), 32'(exp_a[0][c]));
      chk($sformatf("lat3 c%0d", c), 32'(act3), 32'(exp_a[1][c]));
      if (c == 1)   chk("reset_outputs", 32'(act1), 32'd0);
      if (c == 4)   chk("nom_hash_init", 32'(hi1), 32'd1);
      if (c == 21)  chk("nom_first_rd", 32'({rd1, wa1}), 32'({1'b1, 6'd0}));
      if (c == 84)  chk("nom_last_rd", 32'({rd1, wa1, ka1}), 32'({1'b1, 6'd63, 6'd63}));
      if (c == 85)  chk("nom_rd_drop", 32'(rd1), 32'd0);
      if (c == 22)  chk("nom_first_ren", 32'({ren1, ri1}), 32'({1'b1, 6'd0}));
      if (c == 85)  chk("nom_last_ren", 32'({ren1, ri1}), 32'({1'b1, 6'd63}));
      if (c == 23)  chk("lat3_no_ren_early", 32'(ren3), 32'd0);
      if (c == 24)  chk("lat3_first_ren", 32'({ren3, ri3}), 32'({1'b1, 6'd0}));
      if (c == 87)  chk("nom_hash_update", 32'(hu1), 32'd1);
      if (c == 88)  chk("nom_done", 32'({dn1, fin1, bsy1}), 32'h7);
      if (c == 89)  chk("nom_idle", 32'(bsy1), 32'd0);
      if (c == 89)  chk("lat3_hash_update", 32'(hu3), 32'd1);
      if (c == 90)  chk("lat3_done", 32'(dn3), 32'd1);
      if (c == 117) chk("pad_timeout_err", 32'({bsy1, er1}), 32'h1);
      if (c == 126) chk("err_cleared_on_go", 32'(er1), 32'd0);
      if (c == 613) chk("async_reset_zero", 32'(act1), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
